// File: rtl/vga_hex_scan_if.sv
// Beam position and delayed video timing signals produced by vga_hex_scan.
// The master drives everything; decoders and the VGA pin stage use the slave view.
interface vga_hex_scan_if #(
    parameter int c_x_bits = 10,
    parameter int c_y_bits = 10
);
    logic [c_x_bits-1:0] x;
    logic [c_y_bits-1:0] y;
    logic                hsync;
    logic                vsync;
    logic                blank;
    logic                de;
    logic                frame_start;
    logic                vblank_start;

    modport master (
        output x, y, hsync, vsync, blank, de, frame_start, vblank_start
    );

    modport slave (
        input  x, y, hsync, vsync, blank, de, frame_start, vblank_start
    );
endinterface

// File: rtl/vga_hex_scan.sv
// VGA raster scanner: free-running x/y beam counters that feed a pipelined
// hex decoder, plus sync/blank/de delayed by the decoder's pipeline depth so
// they line up with the decoded pixel data.
module vga_hex_scan #(
    parameter int   c_x_bits    = 10,
    parameter int   c_y_bits    = 10,
    parameter int   c_res_x     = 640,
    parameter int   c_hfp       = 16,
    parameter int   c_hsw       = 96,
    parameter int   c_hbp       = 48,
    parameter int   c_res_y     = 480,
    parameter int   c_vfp       = 10,
    parameter int   c_vsw       = 2,
    parameter int   c_vbp       = 33,
    parameter logic c_hsync_pol = 1'b0,
    parameter logic c_vsync_pol = 1'b0,
    parameter int   c_latency   = 4
) (
    input  logic            clk,
    input  logic            reset,
    vga_hex_scan_if.master  bus
);

    localparam int c_h_tot = c_res_x + c_hfp + c_hsw + c_hbp;
    localparam int c_v_tot = c_res_y + c_vfp + c_vsw + c_vbp;

    // All compare constants are sized to the counter width.
    localparam logic [c_x_bits-1:0] c_x_last     = c_x_bits'(c_h_tot - 1);
    localparam logic [c_x_bits-1:0] c_x_vis      = c_x_bits'(c_res_x);
    localparam logic [c_x_bits-1:0] c_hs_first   = c_x_bits'(c_res_x + c_hfp);
    localparam logic [c_x_bits-1:0] c_hs_last    = c_x_bits'(c_res_x + c_hfp + c_hsw - 1);
    localparam logic [c_y_bits-1:0] c_y_last     = c_y_bits'(c_v_tot - 1);
    localparam logic [c_y_bits-1:0] c_y_vis      = c_y_bits'(c_res_y);
    localparam logic [c_y_bits-1:0] c_y_vis_last = c_y_bits'(c_res_y - 1);
    localparam logic [c_y_bits-1:0] c_vs_first   = c_y_bits'(c_res_y + c_vfp);
    localparam logic [c_y_bits-1:0] c_vs_last    = c_y_bits'(c_res_y + c_vfp + c_vsw - 1);

    logic [c_x_bits-1:0] r_x;
    logic [c_y_bits-1:0] r_y;
    logic                r_frame_start;
    logic                r_vblank_start;

    logic w_x_wrap;
    logic w_y_wrap;
    logic w_hs_act;
    logic w_vs_act;
    logic w_hsync;
    logic w_vsync;
    logic w_blank;
    logic w_blank_out;

    assign w_x_wrap = (r_x == c_x_last);
    assign w_y_wrap = (r_y == c_y_last);

    // Undelayed timing terms decoded from the current beam position.
    assign w_hs_act = (r_x >= c_hs_first) && (r_x <= c_hs_last);
    assign w_vs_act = (r_y >= c_vs_first) && (r_y <= c_vs_last);
    assign w_hsync  = w_hs_act ? c_hsync_pol : ~c_hsync_pol;
    assign w_vsync  = w_vs_act ? c_vsync_pol : ~c_vsync_pol;
    assign w_blank  = (r_x >= c_x_vis) || (r_y >= c_y_vis);

    // Beam counters and the frame/vblank strobes, which fire on the wrap edge itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x            <= '0;
            r_y            <= '0;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge x/y; blocking would let the y update see the already-wrapped x.
            r_frame_start  <= w_x_wrap && w_y_wrap;
            r_vblank_start <= w_x_wrap && (r_y == c_y_vis_last);
            if (w_x_wrap) begin
                r_x <= '0;
                r_y <= w_y_wrap ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    generate
        if (c_latency == 0) begin : g_direct
            assign bus.hsync = w_hsync;
            assign bus.vsync = w_vsync;
            assign w_blank_out = w_blank;
        end else begin : g_pipe
            logic [c_latency-1:0] r_hs_pipe;
            logic [c_latency-1:0] r_vs_pipe;
            logic [c_latency-1:0] r_bl_pipe;
            logic [c_latency:0]   w_hs_chain;
            logic [c_latency:0]   w_vs_chain;
            logic [c_latency:0]   w_bl_chain;

            // Bit 0 of each chain is the undelayed term, the top bit is the output.
            assign w_hs_chain = {r_hs_pipe, w_hsync};
            assign w_vs_chain = {r_vs_pipe, w_vsync};
            assign w_bl_chain = {r_bl_pipe, w_blank};

            // Delay line matching the decoder depth; shifts every pixel clock.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    // NOTE: the delay stages are reset (not left unknown) because they
                    // drive the monitor directly; reset must show a blanked, sync-idle screen.
                    r_hs_pipe <= {c_latency{~c_hsync_pol}};
                    r_vs_pipe <= {c_latency{~c_vsync_pol}};
                    r_bl_pipe <= {c_latency{1'b1}};
                end else begin
                    r_hs_pipe <= w_hs_chain[c_latency-1:0];
                    r_vs_pipe <= w_vs_chain[c_latency-1:0];
                    r_bl_pipe <= w_bl_chain[c_latency-1:0];
                end
            end

            assign bus.hsync   = w_hs_chain[c_latency];
            assign bus.vsync   = w_vs_chain[c_latency];
            assign w_blank_out = w_bl_chain[c_latency];
        end
    endgenerate

    assign bus.x            = r_x;
    assign bus.y            = r_y;
    assign bus.blank        = w_blank_out;
    assign bus.de           = ~w_blank_out;
    assign bus.frame_start  = r_frame_start;
    assign bus.vblank_start = r_vblank_start;

endmodule

// File: doc/vga_hex_scan.md
VGA_HEX_SCAN -- requirements
Module: vga_hex_scan

Interface
REQ-001 c_x_bits, 10, width of x output.
REQ-002 c_y_bits, 10, width of y output.
REQ-003 c_res_x / c_hfp / c_hsw / c_hbp, 640 / 16 / 96 / 48, visible width, H front porch, H sync width, H back porch (pixels).
REQ-004 c_res_y / c_vfp / c_vsw / c_vbp, 480 / 10 / 2 / 33, visible height, V front porch, V sync width, V back porch (lines).
REQ-005 c_hsync_pol / c_vsync_pol, 0 / 0, active level of hsync / vsync (0 = active-low).
REQ-006 c_latency, 4, clocks by which hsync, vsync, blank and de lag x/y; range 0..8; matches the hex decoder pipeline depth.
REQ-007 clk  in  1  pixel clock, one pixel per rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 x  out  c_x_bits  horizontal beam counter, undelayed, feeds the decoder.
REQ-010 y  out  c_y_bits  vertical beam counter, undelayed, feeds the decoder.
REQ-011 hsync  out  1  horizontal sync, delayed c_latency.
REQ-012 vsync  out  1  vertical sync, delayed c_latency.
REQ-013 blank  out  1  1 outside the visible area, delayed c_latency.
REQ-014 de  out  1  inverse of blank, delayed c_latency.
REQ-015 frame_start  out  1  one-clock pulse, undelayed, when the counters enter (0,0) from a wrap.
REQ-016 vblank_start  out  1  one-clock pulse, undelayed, when the counters enter (0,c_res_y); safe point to latch new decoder data.

Function
REQ-017 Totals SHALL be H_T = c_res_x+c_hfp+c_hsw+c_hbp and V_T = c_res_y+c_vfp+c_vsw+c_vbp.
REQ-018 x SHALL increment by 1 every clock, and SHALL wrap from H_T-1 to 0.
REQ-019 y SHALL increment by 1 only on the clock where x wraps, and SHALL wrap from V_T-1 to 0 on that same clock.
REQ-020 The undelayed hsync term SHALL be active for x in [c_res_x+c_hfp, c_res_x+c_hfp+c_hsw-1]. Its output level is c_hsync_pol when active and the inverse otherwise.
REQ-021 The undelayed vsync term SHALL be active for y in [c_res_y+c_vfp, c_res_y+c_vfp+c_vsw-1], for whole lines (x = 0..H_T-1). Its output level is c_vsync_pol when active and the inverse otherwise.
REQ-022 The undelayed blank term SHALL be 1 when x >= c_res_x or y >= c_res_y.
REQ-023 hsync, vsync, blank and de SHALL equal their undelayed terms of exactly c_latency clocks earlier.
REQ-024 The delay SHALL be a shift register of length c_latency that advances every clock.
REQ-025 When c_latency = 0, hsync, vsync, blank and de SHALL be decoded directly from the x/y registers.
REQ-026 de SHALL always equal NOT blank, in the same cycle.
REQ-027 frame_start SHALL be a register set on the clock edge where the counters move from (H_T-1, V_T-1) to (0,0), and cleared on the following edge.
REQ-028 vblank_start SHALL be a register set on the clock edge where the counters move from (H_T-1, c_res_y-1) to (0, c_res_y), and cleared on the following edge.
REQ-029 All counter compares SHALL be performed at c_x_bits / c_y_bits width; parameter sets with H_T > 2^c_x_bits or V_T > 2^c_y_bits are illegal.

Reset
REQ-030 While reset = 1: x = 0, y = 0, frame_start = 0, vblank_start = 0.
REQ-031 While reset = 1: every delay stage SHALL hold blank = 1, de = 0, and hsync/vsync at their inactive levels.
REQ-032 The first edge after reset release SHALL advance x to 1; no frame_start pulse SHALL occur for the post-reset frame start.
REQ-033 Reset asserted mid-frame SHALL immediately force REQ-030/031 values, with no partial pulse emitted.

Verification
REQ-034 Default params, run one full frame -> x wraps at 799, y wraps at 524; exactly 420000 clocks between frame_start pulses.
REQ-035 Default params, check sync alignment -> hsync low for exactly 96 clocks per line, first low cycle when x = 660 (656+4); vsync low for 1600 clocks, starting when y = 490, x = 4.
REQ-036 Default params, check visible area -> de high exactly 640 consecutive clocks per visible line, 307200 per frame, first high when x = 4, y = 0.
REQ-037 Default params, observe line transitions -> vblank_start pulses once per frame, in the cycle where x = 0, y = 480; it never coincides with frame_start.
REQ-038 Assert reset at x = 300, y = 200 for 3 clocks -> x = y = 0, blank = 1, hsync = vsync = 1 during reset; after release x counts 1, 2, 3 and blank stays 1 for 4 clocks.
REQ-039 c_latency = 0, c_hsync_pol = 1 -> hsync high for x in 656..751 in the same cycle; de equals (x < 640 and y < 480) combinationally.
